// File: rtl/msp430_pkg.sv
// Shared types and constants for the MSP430x2xx instruction memory responder.
package msp430_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    ACK  = 2'd3
  } state_t;

  // MOV #0,R3: a harmless instruction handed back for any faulted fetch.
  localparam logic [15:0] DEF_NOP_WORD  = 16'h4303;
  localparam logic [15:0] DEF_BASE_ADDR = 16'hC000;

endpackage

// File: rtl/instr_mem_ram.sv
// Single-port synchronous program store: one write or read per cycle, registered read data.
module instr_mem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [15:0]       i_wdata,
  output logic [15:0]       o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_responder.sv
// Program store front-end: streams words in during LOAD, answers core fetches over req/ack.
// Optional INSTR_MEM_CHECKSUM_EN adds Load_sum, a wrap-around sum of every stored word.
//
// state | meaning
// IDLE  | waiting; Load_en wins over Fetch_req
// LOAD  | accepting words until Load_en drops
// READ  | RAM data for the captured address is valid; fault check and Instr update
// ACK   | Fetch_ack pulse, Instr valid
module instr_mem_responder
  import msp430_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [15:0] NOP_WORD  = DEF_NOP_WORD
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Load_en,
  input  logic              Load_valid,
  input  logic [15:0]       Load_data,
  output logic              Load_full,
  output logic [ADDR_W:0]   Words_loaded,
  input  logic              Fetch_req,
  input  logic [15:0]       Fetch_addr,
  output logic              Fetch_ack,
  output logic [15:0]       Instr,
  output logic              Fetch_err,
  output logic              Busy
`ifdef INSTR_MEM_CHECKSUM_EN
  ,
  output logic [15:0]       Load_sum
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_count;
  logic [15:0]       r_addr;
  logic [15:0]       r_instr;
  logic              r_err;
  logic              w_full;
  logic              w_store;
  logic              w_load_entry;
  logic              w_fault;
  logic [15:0]       w_offset;
  logic [15:0]       w_roffset;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [15:0]       w_rdata;

  assign w_full       = r_count[ADDR_W];
  assign w_load_entry = (r_state == IDLE) && Load_en;
  assign w_store      = (r_state == LOAD) && Load_en && Load_valid && !w_full;

  // RAM is addressed straight from Fetch_addr in IDLE so its data is ready during READ.
  assign w_offset   = Fetch_addr - BASE_ADDR;
  assign w_ram_addr = (r_state == LOAD) ? r_count[ADDR_W-1:0] : ADDR_W'(w_offset >> 1);

  assign w_roffset = r_addr - BASE_ADDR;
  assign w_fault   = r_addr[0] || (r_addr < BASE_ADDR) || ((w_roffset >> 1) >= 16'(r_count));

  instr_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (Clk),
    .i_we    (w_store),
    .i_addr  (w_ram_addr),
    .i_wdata (Load_data),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (Load_en)        w_next = LOAD;
        else if (Fetch_req) w_next = READ;
      end
      LOAD:    if (!Load_en) w_next = IDLE;
      READ:    w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    Fetch_ack = (r_state == ACK);
    Busy      = (r_state == LOAD) || (r_state == READ);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_count <= '0;
      r_addr  <= '0;
      r_instr <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load_entry) begin
        r_count <= '0;
        r_err   <= 1'b0;
      end else if (w_store) begin
        r_count <= r_count + 1'b1;
      end
      if (r_state == IDLE) r_addr <= Fetch_addr;
      if (r_state == READ) begin
        if (w_fault) begin
          r_instr <= NOP_WORD;
          r_err   <= 1'b1;
        end else begin
          r_instr <= w_rdata;
        end
      end
    end
  end

`ifdef INSTR_MEM_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge Clk) begin
    if (!Rst)             r_sum <= '0;
    else if (w_load_entry) r_sum <= '0;
    else if (w_store)      r_sum <= r_sum + Load_data;
  end

  assign Load_sum = r_sum;
`endif

  assign Load_full    = w_full;
  assign Words_loaded = r_count;
  assign Instr        = r_instr;
  assign Fetch_err    = r_err;

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Memory-side responder for the MSP430x2xx core's instruction fetch interface.
- Owns the program store and has two modes.
  - LOAD mode: words stream in while Load_en is high.
  - SERVE mode: answers core fetch requests (PC byte address) with 16-bit instruction words over a req/ack handshake.
- Sits between the boot/load path and the core's fetch stage.

Parameters:
- ADDR_W, 8, word-address width; depth = 2**ADDR_W words.
- BASE_ADDR, 16'hC000, byte address of word 0 (flash start).
- NOP_WORD, 16'h4303, word returned on any faulted fetch (MOV #0,R3).

Ports:
- Clk  in  1  single clock, rising edge.
- Rst  in  1  reset, synchronous, active-low.
- Load_en  in  1  high = LOAD mode; falling edge ends load.
- Load_valid  in  1  Load_data valid this cycle.
- Load_data  in  16  instruction word to store.
- Load_full  out  1  store full; further load words dropped.
- Words_loaded  out  ADDR_W+1  count of words stored.
- Fetch_req  in  1  core requests a word (level, held until ack).
- Fetch_addr  in  16  byte address (PC).
- Fetch_ack  out  1  one-cycle pulse; Instr valid.
- Instr  out  16  fetched word, held until next ack.
- Fetch_err  out  1  sticky; odd address or out-of-range fetch seen.
- Busy  out  1  high in LOAD or READ state.

Behaviour:
- Reset: applied when Rst=0 at a rising edge.
  - State=IDLE; Load_full=0, Words_loaded=0, Fetch_ack=0, Instr=0, Fetch_err=0, Busy=0.
  - Memory contents undefined; the write pointer is zeroed.
- State IDLE:
  - Load_en=1 -> LOAD; write pointer and Words_loaded clear.
  - Else Fetch_req=1 -> READ.
  - Load_en has priority when both are asserted.
- State LOAD:
  - Each cycle with Load_valid=1 and Load_full=0: mem[ptr]<=Load_data, ptr++, Words_loaded++.
  - When Words_loaded reaches 2**ADDR_W, Load_full=1. The pointer does not wrap; later words are dropped silently.
  - Load_en=0 -> IDLE the next cycle. A Load_valid in the same cycle Load_en falls is ignored.
  - Fetch_req is ignored in LOAD; no ack is issued.
- State READ (one cycle; registered memory read):
  - Index = (Fetch_addr - BASE_ADDR) >> 1, 16-bit subtraction.
  - Fault conditions: Fetch_addr[0]=1, Fetch_addr < BASE_ADDR, or index >= Words_loaded.
  - On fault: Instr<=NOP_WORD, Fetch_err<=1.
  - Otherwise: Instr<=mem[index].
  - Fetch_ack=1 for exactly one cycle on the cycle after READ -> state ACK.
- State ACK:
  - Fetch_ack=1 -> IDLE.
  - Fetch_req still high the next cycle starts a new request: a held req is a new fetch of the current Fetch_addr.
  - Latency: request sampled in IDLE -> ack 2 cycles later; throughput 1 word per 3 cycles.
- Fetch_err: cleared only by reset or by entering LOAD.
- Reset mid-operation:
  - Synchronous reset aborts LOAD or READ immediately.
  - No ack is issued for an aborted read.
  - Partially loaded contents are unreachable, because Words_loaded=0.
- Fetch_addr must be stable from IDLE sampling through READ. It is captured into an address register in IDLE.

Optional Feature:
- Macro INSTR_MEM_CHECKSUM_EN.
- When defined:
  - Adds output Load_sum [15:0], a running 16-bit wrap-around sum of every stored word.
  - Cleared on reset and on LOAD entry.
  - Dropped words (Load_full) are not summed.
  - Valid the cycle after the last store.
- When undefined: port and adder absent; behaviour otherwise identical.

Decomposition:
- Shared package msp430_pkg:
  - state enum (IDLE, LOAD, READ, ACK);
  - NOP_WORD constant;
  - BASE_ADDR default.
- One sub-module: instr_mem_ram, a single-port synchronous RAM (write enable, registered read, depth 2**ADDR_W x 16). The responder holds the FSM, pointer and fault logic.

Test Plan:
- Reset: Rst=0 for 2 cycles with Load_en=1 and Fetch_req=1 -> all outputs 0, state IDLE, no ack.
- Load and fetch: load 16'h4031, 16'h0280, 16'h3FFF; drop Load_en; fetch 16'hC002 -> Fetch_ack 2 cycles after req, Instr=16'h0280, Fetch_err=0, Words_loaded=3.
- Faults:
  - fetch 16'hC003 -> Instr=16'h4303, Fetch_err=1;
  - after a reload, fetch 16'hC006 with 3 words loaded -> 16'h4303;
  - fetch 16'hBFFE -> 16'h4303.
- Full: load 257 words with ADDR_W=8 -> Load_full=1 after word 256, Words_loaded=256; word 257 not stored; fetch 16'hC1FE returns word 256.
- Priority and abort:
  - Load_en and Fetch_req rising together -> LOAD, no ack;
  - Rst=0 during READ -> no ack, Instr=0.
- Checksum (INSTR_MEM_CHECKSUM_EN defined): load 16'hFFFF and 16'h0002 -> Load_sum=16'h0001.
